// File: rtl/peri_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | peri_pkg -- shared types and defaults for the serial peripheral port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package peri_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4
  } peri_state_t;

  localparam int REQ_CPU    = 0;
  localparam int REQ_MIRROR = 1;

  localparam int PERI_WIDTH = 16;
  localparam int PERI_DIV   = 4;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2 -- combinational two-way round-robin pick                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arb2
  import peri_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'(REQ_CPU);
    case (req)
      2'b01:   grant_idx = 1'(REQ_CPU);
      2'b10:   grant_idx = 1'(REQ_MIRROR);
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'(REQ_CPU);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/peri_serial_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | peri_serial_scheduler -- arbitrates two requesters onto P_CLOCK/DATA/CS |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module peri_serial_scheduler
  import peri_pkg::*;
#(
  parameter int WIDTH = PERI_WIDTH,
  parameter int DIV   = PERI_DIV
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] word0,
  input  logic [WIDTH-1:0] word1,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             P_CLOCK,
  output logic             P_DATA,
  output logic             P_CS
);

  localparam int             IDX_W    = $clog2(WIDTH);
  localparam logic [7:0]     DIV_LAST = 8'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  peri_state_t      state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic             last_grant, last_grant_nxt;
  logic [1:0]       ack_nxt;
  logic             busy_nxt, pclk_nxt, pdata_nxt, pcs_nxt;

  logic             grant_valid, grant_idx;
  logic [WIDTH-1:0] sel_word;
  logic             dwell_done;

  rr_arb2 u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_word   = grant_idx ? word1 : word0;
  assign dwell_done = (cnt == DIV_LAST);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + 8'd1;
    idx_nxt        = idx;
    shift_nxt      = shift;
    last_grant_nxt = last_grant;
    ack_nxt        = 2'b00;
    busy_nxt       = busy;
    pclk_nxt       = P_CLOCK;
    pdata_nxt      = P_DATA;
    pcs_nxt        = P_CS;

    case (state)
      IDLE: begin
        cnt_nxt = 8'd0;
        if (grant_valid) begin
          state_nxt          = SETUP;
          shift_nxt          = sel_word;
          idx_nxt            = IDX_TOP;
          last_grant_nxt     = grant_idx;
          ack_nxt[grant_idx] = 1'b1;
          busy_nxt           = 1'b1;
          pcs_nxt            = 1'b0;
          pclk_nxt           = 1'b0;
          pdata_nxt          = sel_word[WIDTH-1];
        end
      end
      SETUP, LOW: begin
        if (dwell_done) begin
          state_nxt = HIGH;
          cnt_nxt   = 8'd0;
          pclk_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (dwell_done) begin
          cnt_nxt  = 8'd0;
          pclk_nxt = 1'b0;
          if (idx == '0) begin
            state_nxt = HOLD;
            pdata_nxt = 1'b0;
          end else begin
            // Shift left so the next bit is always at the top of the register.
            state_nxt = LOW;
            idx_nxt   = idx - IDX_ONE;
            shift_nxt = shift << 1;
            pdata_nxt = shift[WIDTH-2];
          end
        end
      end
      HOLD: begin
        if (dwell_done) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
          pcs_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      idx        <= IDX_TOP;
      shift      <= '0;
      last_grant <= 1'b1;
      ack        <= 2'b00;
      busy       <= 1'b0;
      P_CLOCK    <= 1'b0;
      P_DATA     <= 1'b0;
      P_CS       <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      shift      <= shift_nxt;
      last_grant <= last_grant_nxt;
      ack        <= ack_nxt;
      busy       <= busy_nxt;
      P_CLOCK    <= pclk_nxt;
      P_DATA     <= pdata_nxt;
      P_CS       <= pcs_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peri_serial_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_peri_serial_scheduler -- directed + random bench, DIV=4 and DIV=1 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_peri_serial_scheduler;

  localparam int WIDTH = 16;
  localparam int BUSY4 = 4 * (2 * WIDTH + 1);
  localparam int BUSY1 = 1 * (2 * WIDTH + 1);

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, req1;
  logic [15:0] word0, word1, w1_0, w1_1;
  logic [1:0]  ack, ack1;
  logic        busy, P_CLOCK, P_DATA, P_CS;
  logic        busy1, pclk1, pdata1, pcs1;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  peri_serial_scheduler #(.WIDTH(16), .DIV(4)) dut (
    .clock(clock), .reset(reset), .req(req), .word0(word0), .word1(word1),
    .ack(ack), .busy(busy), .P_CLOCK(P_CLOCK), .P_DATA(P_DATA), .P_CS(P_CS)
  );

  peri_serial_scheduler #(.WIDTH(16), .DIV(1)) dut1 (
    .clock(clock), .reset(reset), .req(req1), .word0(w1_0), .word1(w1_1),
    .ack(ack1), .busy(busy1), .P_CLOCK(pclk1), .P_DATA(pdata1), .P_CS(pcs1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: lone requester wins, a tie goes to whoever did not win last.
  function automatic logic pick(input logic [1:0] r, input logic lg);
    if (r == 2'b01) return 1'b0;
    if (r == 2'b10) return 1'b1;
    return ~lg;
  endfunction

  // Protocol watchers on both instances.
  logic       pclk_q = 1'b0, pdata_q = 1'b0, pclk1_q = 1'b0, pdata1_q = 1'b0;
  logic [1:0] ack_q = 2'b00, ack1_q = 2'b00;

  always @(negedge clock) begin
    if (pclk_q && P_CLOCK) check("proto_data_stable", {31'b0, P_DATA}, {31'b0, pdata_q});
    if (P_CS) check("proto_clk_idle", {31'b0, P_CLOCK}, 32'd0);
    check("proto_ack_both", {31'b0, ack == 2'b11}, 32'd0);
    if (ack_q != 2'b00) check("proto_ack_pulse", {30'b0, ack}, 32'd0);
    if (pclk1_q && pclk1) check("proto1_data_stable", {31'b0, pdata1}, {31'b0, pdata1_q});
    if (pcs1) check("proto1_clk_idle", {31'b0, pclk1}, 32'd0);
    check("proto1_ack_both", {31'b0, ack1 == 2'b11}, 32'd0);
    if (ack1_q != 2'b00) check("proto1_ack_pulse", {30'b0, ack1}, 32'd0);
    pclk_q   <= P_CLOCK;
    pdata_q  <= P_DATA;
    ack_q    <= ack;
    pclk1_q  <= pclk1;
    pdata1_q <= pdata1;
    ack1_q   <= ack1;
  end

  // Follow one DIV=4 transfer from the cycle req is presented to the IDLE cycle after it.
  task automatic watch(input logic [1:0] exp_ack, input logic [15:0] exp_word,
                       input logic [1:0] clr, input int late, input string tag);
    int n, blen, bits;
    logic [15:0] got;
    logic prev;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ack == 2'b00 && n < 300);
    check({tag, "_ack"}, {30'b0, ack}, {30'b0, exp_ack});
    check({tag, "_ack_latency"}, n, 1);
    check({tag, "_cs_low"}, {31'b0, P_CS}, 32'd0);
    req  = req & ~clr;
    blen = 0;
    bits = 0;
    got  = '0;
    prev = P_CLOCK;
    while (busy === 1'b1 && blen < 1000) begin
      blen++;
      if (blen == late) begin
        word1  = 16'($urandom);
        req[1] = 1'b1;
      end
      @(negedge clock);
      if (late > 0 && busy === 1'b1) check({tag, "_no_early_ack"}, {30'b0, ack}, 32'd0);
      if (P_CLOCK && !prev) begin
        got = {got[14:0], P_DATA};
        bits++;
      end
      prev = P_CLOCK;
    end
    check({tag, "_busy_len"}, blen, BUSY4);
    check({tag, "_bits"}, bits, WIDTH);
    check({tag, "_word"}, {16'b0, got}, {16'b0, exp_word});
    check({tag, "_cs_idle"}, {31'b0, P_CS}, 32'd1);
  endtask

  // DIV=1 instance: clock must toggle every cycle from SETUP through HOLD.
  task automatic watch1(input logic [15:0] w, input string tag);
    int n, blen, bits;
    logic [15:0] got;
    logic prev;
    w1_0 = w;
    req1 = 2'b01;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ack1 == 2'b00 && n < 300);
    check({tag, "_ack"}, {30'b0, ack1}, 32'd1);
    check({tag, "_ack_latency"}, n, 1);
    req1 = 2'b00;
    blen = 0;
    bits = 0;
    got  = '0;
    prev = pclk1;
    while (busy1 === 1'b1 && blen < 200) begin
      blen++;
      check({tag, "_toggle"}, {31'b0, pclk1}, {31'b0, (blen % 2) == 0});
      @(negedge clock);
      if (pclk1 && !prev) begin
        got = {got[14:0], pdata1};
        bits++;
      end
      prev = pclk1;
    end
    check({tag, "_busy_len"}, blen, BUSY1);
    check({tag, "_word"}, {16'b0, got}, {16'b0, w});
    check({tag, "_cs_idle"}, {31'b0, pcs1}, 32'd1);
  endtask

  initial begin
    logic        last_g;
    logic        g;
    logic [1:0]  pat;
    int          n, bits;
    logic        prev;

    reset = 1'b1;
    req   = 2'b00;
    req1  = 2'b00;
    word0 = '0;
    word1 = '0;
    w1_0  = '0;
    w1_1  = '0;
    last_g = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_cs", {31'b0, P_CS}, 32'd1);
    check("rst_clk", {31'b0, P_CLOCK}, 32'd0);
    check("rst_data", {31'b0, P_DATA}, 32'd0);
    check("rst_ack", {30'b0, ack}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single transfer with the reference pattern.
    word0 = 16'hA5C3;
    req   = 2'b01;
    watch(2'b01, 16'hA5C3, 2'b01, 0, "single");
    last_g = 1'b0;

    // Late request from requester 1 during a requester-0 transfer.
    @(negedge clock);
    word0 = 16'($urandom);
    req   = 2'b01;
    watch(2'b01, word0, 2'b01, 50, "late0");
    watch(2'b10, word1, 2'b10, 0, "late1");
    last_g = 1'b1;

    // Randomized request patterns against the round-robin rule.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      word0 = 16'($urandom);
      word1 = 16'($urandom);
      pat   = 2'($urandom_range(1, 3));
      req   = pat;
      g     = pick(pat, last_g);
      watch(g ? 2'b10 : 2'b01, g ? word1 : word0, 2'b11, 0, "rand");
      last_g = g;
    end

    // Reset while bit 7 is on the wire.
    @(negedge clock);
    word0 = 16'($urandom);
    req   = 2'b01;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (ack == 2'b00 && n < 300);
    req  = 2'b00;
    bits = 0;
    prev = P_CLOCK;
    while (bits < 9 && n < 1000) begin
      @(negedge clock);
      n++;
      if (P_CLOCK && !prev) bits++;
      prev = P_CLOCK;
    end
    check("midrst_reached_bit7", bits, 9);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_cs", {31'b0, P_CS}, 32'd1);
    check("midrst_clk", {31'b0, P_CLOCK}, 32'd0);
    check("midrst_data", {31'b0, P_DATA}, 32'd0);
    check("midrst_ack", {30'b0, ack}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    last_g = 1'b1;

    // Tie from reset with both requests held: grants alternate 0,1,0.
    word0 = 16'h0001;
    word1 = 16'h8000;
    req   = 2'b11;
    watch(2'b01, 16'h0001, 2'b00, 0, "tie_a");
    watch(2'b10, 16'h8000, 2'b00, 0, "tie_b");
    watch(2'b01, 16'h0001, 2'b11, 0, "tie_c");

    // DIV=1 instance.
    @(negedge clock);
    watch1(16'hFFFF, "div1_ffff");
    @(negedge clock);
    watch1(16'($urandom), "div1_rand");

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peri_serial_scheduler.md
# peri_serial_scheduler

Shares the single three-wire peripheral port (P_CLOCK, P_DATA, P_CS) between two word-sized requesters: the CPU peripheral-store path (requester 0) and the register-mirror/debug path (requester 1). The block arbitrates round-robin, latches the granted word and serializes it MSB-first at a divided bit rate. It sits between the computer core and the board GPIO/LED assignments in the top level. It replaces direct core-driven toggling of the port.

## Interface
Parameters:
- WIDTH, 16, bits per transfer (word width of the register file)
- DIV, 4, system clock cycles per serial half-period; legal range 1..255

Ports:
- clock  in  1  system clock (divided system clock of the computer)
- reset  in  1  synchronous, active-high reset; one clock, sampled on rising edge
- req  in  2  req[i] level request from requester i; held until ack[i]
- word0  in  WIDTH  data of requester 0; must be stable while req[0] high
- word1  in  WIDTH  data of requester 1; must be stable while req[1] high
- ack  out  2  one-cycle pulse: word of requester i latched, transfer started
- busy  out  1  high in every state except IDLE
- P_CLOCK  out  1  serial clock, idle low
- P_DATA  out  1  serial data, changes only while P_CLOCK low
- P_CS  out  1  chip select, active low, idle high

## Operation
- States: IDLE, SETUP, LOW, HIGH, HOLD. All outputs registered.
- Reset values: state IDLE, ack=00, busy=0, P_CLOCK=0, P_DATA=0, P_CS=1, last_grant=1 (requester 0 wins first tie), bit index=WIDTH-1, divider count=0.
- Reset mid-transfer aborts immediately: next cycle outputs are at reset values. No partial word is resumed.
- IDLE: if any req bit high, grant one:
  - if only one requester is asking, grant it;
  - if both are asking, grant the one not equal to last_grant.
- On grant: latch the word into the shift register, update last_grant, pulse ack[grant] for exactly one cycle, go to SETUP.
- SETUP: P_CS=0, P_CLOCK=0, P_DATA=shift[WIDTH-1]; lasts DIV cycles, then go to HIGH.
- HIGH: P_CLOCK=1; data held; lasts DIV cycles.
  - If bit index is 0, go to HOLD.
  - Otherwise go to LOW: decrement the index and drive the next bit.
- LOW: P_CLOCK=0, P_DATA=next bit; lasts DIV cycles, then go to HIGH.
- HOLD: P_CS=0, P_CLOCK=0, P_DATA=0; lasts DIV cycles, then go to IDLE with P_CS=1.
- req is ignored outside IDLE. A requester that keeps req high after ack is re-granted at the next IDLE, subject to round-robin.
- Divider: an 8-bit counter reloads at each state entry and terminates at DIV-1.

## Timing
- Cycle 0: req first seen high in IDLE. Cycle 1: ack high, busy=1, P_CS=0, first data bit valid.
- The first P_CLOCK rise is at cycle 1+DIV.
- Each bit has P_CLOCK high for DIV cycles and low for DIV cycles. Setup and hold time of data around the rising edge is DIV cycles each.
- Busy duration per transfer: DIV·(2·WIDTH+1) cycles. At default values this is 4·33 = 132 cycles.
- Between transfers P_CS is high for at least 1 cycle (the IDLE cycle); busy is low in that cycle.
- Back-to-back with both req held: grants alternate 0,1,0,1…; a new ack arrives every DIV·(2·WIDTH+1)+1 cycles.
- A req asserted in the same cycle the block returns to IDLE is granted on the following edge.

## Structure
- Shared package peri_pkg holds:
  - the state enum (IDLE, SETUP, LOW, HIGH, HOLD);
  - requester index constants REQ_CPU=0, REQ_MIRROR=1;
  - the default PERI_WIDTH=16 and PERI_DIV=4 constants for top-level instantiation.
- One sub-module, rr_arb2:
  - combinational two-way round-robin pick from req and last_grant;
  - outputs grant_valid and grant_idx.
- Timing FSM, divider and shift register live in peri_serial_scheduler.

## Test plan
- Reset:
  - check P_CS=1, P_CLOCK=0, P_DATA=0, ack=00, busy=0;
  - assert reset for 1 cycle at bit 7 of a live transfer and check reset values on the next cycle.
- Single transfer: req=01, word0=16'hA5C3, DIV=4.
  - ack[0] pulses at cycle 1.
  - Sample P_DATA on 16 rising P_CLOCK edges and read 1010010111000011.
  - busy lasts 132 cycles; P_CS rises at cycle 133.
- Tie: req=11 from reset with word0=16'h0001, word1=16'h8000.
  - First grant goes to 0, second to 1, third to 0.
  - The serial words observed are 0001, 8000, 0001.
- Late request: raise req[1] at cycle 50 of a requester-0 transfer.
  - No ack[1] until the transfer ends.
  - ack[1] pulses exactly 1 cycle after busy falls, with exactly one P_CS-high cycle between the two transfers.
- DIV=1, WIDTH=16, word0=16'hFFFF:
  - P_CLOCK toggles every cycle;
  - busy lasts 33 cycles;
  - P_DATA never changes while P_CLOCK is high.
- Protocol checker on all scenarios:
  - P_DATA is stable whenever P_CLOCK=1;
  - P_CLOCK=0 whenever P_CS=1;
  - ack is never high for more than 1 cycle or on both bits at once.
